alu_key_seq: RTL and testbench
==============================

ALU_KEY_SEQ -- requirements
Module: alu_key_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand/result width; legal values 4..32, power of two.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, clock cycles a raw key level must be stable before it is accepted; minimum 2.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 key_up  input  1  raw pushbutton, active-low, asynchronous to clk.
REQ-006 key_down  input  1  raw pushbutton, active-low, asynchronous to clk.
REQ-007 dina  input  DATA_WIDTH  operand A.
REQ-008 dinb  input  DATA_WIDTH  operand B; low log2(DATA_WIDTH) bits are the shift amount for shifts.
REQ-009 opcode  output  4  current operation select.
REQ-010 op_chg  output  1  one-cycle pulse when opcode changes.
REQ-011 doutr  output  DATA_WIDTH  registered result.
REQ-012 doutz  output  1  registered zero flag, high when doutr is all zeros.
REQ-013 flag_of  output  1  registered signed-overflow flag.

Function
REQ-014 Each key SHALL pass a 2-flop synchroniser, then a per-key debounce counter; the debounced level SHALL update only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce back SHALL clear the counter.
REQ-015 A press event SHALL be a one-cycle pulse on the debounced level's 1->0 transition; release SHALL produce no event.
REQ-016 Opcode map: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SLL A by B, 7 SRL A by B, 8 SRA A by B; codes 9..15 SHALL never be held.
REQ-017 Up event alone: opcode+1, 8 wraps to 0. Down event alone: opcode-1, 0 wraps to 8.
REQ-018 Up and down events in the same cycle SHALL leave opcode unchanged and SHALL NOT pulse op_chg.
REQ-019 op_chg SHALL be high in the cycle opcode shows its new value, for exactly one cycle.
REQ-020 Datapath is two stages: stage 1 registers dina, dinb, opcode; stage 2 computes and registers doutr, doutz, flag_of; latency from inputs to outputs SHALL be exactly 2 cycles, throughput one result per cycle.
REQ-021 ADD/SUB results SHALL be truncated to DATA_WIDTH; flag_of SHALL be signed two's-complement overflow for ADD/SUB and 0 for all other ops.
REQ-022 SRA SHALL replicate bit DATA_WIDTH-1; SLL/SRL SHALL zero-fill; shift amount 0 SHALL pass A unchanged.
REQ-023 doutz SHALL be computed from the same truncated result registered into doutr.

Reset
REQ-024 While rst_n is low at a clock edge: opcode=0, op_chg=0, doutr=0, doutz=1, flag_of=0, pipeline registers 0, synchronisers and debounced levels=1 (released), debounce counters=0.
REQ-025 Reset asserted mid-debounce or mid-pipeline SHALL discard the pending key event and in-flight results; first valid result appears 2 cycles after the first non-reset edge.
REQ-026 A key held pressed across reset release SHALL be accepted as a press only after DEBOUNCE_CYCLES stable cycles post-reset.

Verification (DATA_WIDTH=8, DEBOUNCE_CYCLES=4 unless noted)
REQ-027 Reset, opcode=0, dina=8'h7F, dinb=8'h01 -> 2 cycles later doutr=8'h80, flag_of=1, doutz=0.
REQ-028 key_up low with 3-cycle glitches, then steady low 4+ cycles -> exactly one op_chg pulse, opcode 0->1; SUB dina=8'h05, dinb=8'h05 -> doutr=0, doutz=1, flag_of=0.
REQ-029 Nine up presses from opcode=0 -> opcode returns to 0; one down press from 0 -> opcode=8.
REQ-030 opcode=8, dina=8'h90, dinb=8'h03 -> doutr=8'hF2; opcode=7 same operands -> doutr=8'h12; opcode=6 -> 8'h80.
REQ-031 key_up and key_down debounced-pressed in the same cycle -> opcode unchanged, op_chg stays 0.
REQ-032 Reset asserted 2 cycles into a key debounce and during a changing operand stream -> all outputs at reset values, no opcode change after release until a fresh stable press.

Source files
------------

// File: rtl/alu_key_seq_if.sv
// Bus bundle for alu_key_seq: raw keys and operands in, opcode/result out.
interface alu_key_seq_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  key_up;
    logic                  key_down;
    logic [DATA_WIDTH-1:0] dina;
    logic [DATA_WIDTH-1:0] dinb;
    logic [3:0]            opcode;
    logic                  op_chg;
    logic [DATA_WIDTH-1:0] doutr;
    logic                  doutz;
    logic                  flag_of;

    // Stimulus side: drives keys and operands, observes results.
    modport master (
        output key_up, key_down, dina, dinb,
        input  opcode, op_chg, doutr, doutz, flag_of
    );

    // Design side.
    modport slave (
        input  key_up, key_down, dina, dinb,
        output opcode, op_chg, doutr, doutz, flag_of
    );
endinterface

// File: rtl/alu_key_seq.sv
// Key-selected ALU: two debounced pushbuttons step the opcode up/down,
// and a two-stage pipeline computes the selected operation on dina/dinb.
module alu_key_seq #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input logic          clk,
    input logic          rst_n,
    alu_key_seq_if.slave bus
);
    localparam int MSB   = DATA_WIDTH - 1;
    localparam int SH_W  = $clog2(DATA_WIDTH);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7,
        OP_SRA = 4'd8
    } op_e;

    // Index 0 is key_up, index 1 is key_down; all levels active-low.
    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       level;
    logic [CNT_W-1:0] cnt [2];
    logic [1:0]       press;

    assign raw = {bus.key_down, bus.key_up};

    // Two-flop synchroniser, reset to the released level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: level follows sync2 only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level  <= 2'b11;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] != level[k]) begin
                    if (cnt[k] == CNT_LAST) begin
                        level[k] <= sync2[k];
                        cnt[k]   <= '0;
                    end else begin
                        cnt[k] <= cnt[k] + 1'b1;
                    end
                end else begin
                    cnt[k] <= '0;
                end
            end
        end
    end

    // Press event: the cycle in which the debounced level commits a 1->0 change.
    always_comb begin
        press = 2'b00;
        for (int k = 0; k < 2; k++) begin
            press[k] = level[k] & ~sync2[k] & (cnt[k] == CNT_LAST);
        end
    end

    // Opcode selector state; op_chg is registered with it so both show together.
    op_e  state_q;
    op_e  state_nxt;
    logic chg_q;
    logic chg_nxt;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= OP_ADD;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            chg_q   <= chg_nxt;
        end
    end

    // Next state: up alone increments, down alone decrements, both cancel out.
    always_comb begin
        state_nxt = state_q;
        chg_nxt   = 1'b0;
        case (press)
            2'b01: begin
                state_nxt = (state_q == OP_SRA) ? OP_ADD : op_e'(state_q + 4'd1);
                chg_nxt   = 1'b1;
            end
            2'b10: begin
                state_nxt = (state_q == OP_ADD) ? OP_SRA : op_e'(state_q - 4'd1);
                chg_nxt   = 1'b1;
            end
            default: begin
                state_nxt = state_q;
                chg_nxt   = 1'b0;
            end
        endcase
    end

    // Outputs of the selector (opcode doubles as the visible state).
    always_comb begin
        bus.opcode = state_q;
        bus.op_chg = chg_q;
    end

    // Stage 1 operand/opcode registers.
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    op_e                   op_q;

    // Stage 1: capture operands together with the opcode in force this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_ADD;
        end else begin
            a_q  <= bus.dina;
            b_q  <= bus.dinb;
            op_q <= state_q;
        end
    end

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic [SH_W-1:0]       sh;
    logic [DATA_WIDTH-1:0] res;
    logic                  ovf;

    assign sum  = a_q + b_q;
    assign diff = a_q - b_q;
    assign sh   = b_q[SH_W-1:0];

    // Stage 2 combinational ALU; overflow only meaningful for ADD/SUB.
    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (op_q)
            OP_ADD: begin
                res = sum;
                ovf = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                res = diff;
                ovf = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
            end
            OP_AND:  res = a_q & b_q;
            OP_OR:   res = a_q | b_q;
            OP_XOR:  res = a_q ^ b_q;
            OP_NOT:  res = ~a_q;
            OP_SLL:  res = a_q << sh;
            OP_SRL:  res = a_q >> sh;
            OP_SRA:  res = $unsigned($signed(a_q) >>> sh);
            default: res = '0;
        endcase
    end

    logic [DATA_WIDTH-1:0] doutr_q;
    logic                  doutz_q;
    logic                  flag_of_q;

    // Stage 2 result registers; zero flag derived from the same truncated result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            doutr_q   <= '0;
            doutz_q   <= 1'b1;
            flag_of_q <= 1'b0;
        end else begin
            doutr_q   <= res;
            doutz_q   <= (res == '0);
            flag_of_q <= ovf;
        end
    end

    assign bus.doutr   = doutr_q;
    assign bus.doutz   = doutz_q;
    assign bus.flag_of = flag_of_q;
endmodule

// File: tb/tb_alu_key_seq.sv
// Bench for alu_key_seq: directed key/boundary scenarios plus randomized
// operands checked against an arithmetic reference model.
module tb_alu_key_seq;
    localparam int W   = 8;
    localparam int DEB = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   chg_cnt;
    int   exp_op;
    logic [W+1:0] exp_q[$];

    alu_key_seq_if #(.DATA_WIDTH(W)) bus ();

    alu_key_seq #(.DATA_WIDTH(W), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count op_chg pulses, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        if (bus.op_chg === 1'b1) chg_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // reference model: {flag_of, doutz, doutr} from plain integer arithmetic
    function automatic logic [W+1:0] model(input int op, input int a, input int b);
        int sa, sb, s, r, sh;
        logic of;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sh = b % 8;
        of = 1'b0;
        r  = 0;
        case (op)
            0: begin s = sa + sb; r = (a + b) % 256;       of = (s > 127) || (s < -128); end
            1: begin s = sa - sb; r = (a - b + 256) % 256; of = (s > 127) || (s < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: r = (a * (1 << sh)) % 256;
            7: r = a / (1 << sh);
            8: begin s = sa >>> sh; r = (s + 256) % 256; end
            default: r = 0;
        endcase
        return {of, (r == 0), 8'(r)};
    endfunction

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_opcode"}, 32'(bus.opcode), 0);
        check_val({tag, "_op_chg"}, 32'(bus.op_chg), 0);
        check_val({tag, "_doutr"}, 32'(bus.doutr), 0);
        check_val({tag, "_doutz"}, 32'(bus.doutz), 1);
        check_val({tag, "_flag_of"}, 32'(bus.flag_of), 0);
    endtask

    // hold the given keys low long enough to be accepted, then release fully
    task automatic press_keys(input logic up, input logic dn);
        bus.key_up   = up;
        bus.key_down = dn;
        tick(DEB + 4);
        bus.key_up   = 1'b1;
        bus.key_down = 1'b1;
        tick(DEB + 4);
    endtask

    task automatic up_press();
        press_keys(1'b0, 1'b1);
        exp_op = (exp_op + 1) % 9;
    endtask

    task automatic down_press();
        press_keys(1'b1, 1'b0);
        exp_op = (exp_op + 8) % 9;
    endtask

    task automatic goto_op(input int target);
        int c0;
        int n;
        c0 = chg_cnt;
        n  = (target - exp_op + 9) % 9;
        repeat (n) up_press();
        check_val("goto_opcode", 32'(bus.opcode), 32'(target));
        check_val("goto_chg_count", 32'(chg_cnt - c0), 32'(n));
    endtask

    task automatic apply_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] r, input logic z, input logic of);
        bus.dina = a;
        bus.dinb = b;
        tick(2);
        check_val({tag, "_doutr"}, 32'(bus.doutr), 32'(r));
        check_val({tag, "_doutz"}, 32'(bus.doutz), 32'(z));
        check_val({tag, "_flag_of"}, 32'(bus.flag_of), 32'(of));
    endtask

    function automatic int pick_operand();
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0: return 8'h7F;
            1: return 8'h80;
            2: return 8'hFF;
            3: return 8'h00;
            default: return $urandom_range(0, 255);
        endcase
    endfunction

    // stream random operands one per cycle; results compared two cycles later
    task automatic run_random(input int n);
        logic [W+1:0] e;
        int a;
        int b;
        exp_q.delete();
        for (int i = 0; i < n + 2; i++) begin
            if (i >= 2) begin
                e = exp_q.pop_front();
                check_val("rand_doutr", 32'(bus.doutr), 32'(e[W-1:0]));
                check_val("rand_doutz", 32'(bus.doutz), 32'(e[W]));
                check_val("rand_flag_of", 32'(bus.flag_of), 32'(e[W+1]));
            end
            if (i < n) begin
                a = pick_operand();
                b = pick_operand();
                bus.dina = W'(a);
                bus.dinb = W'(b);
                exp_q.push_back(model(exp_op, a, b));
            end
            tick(1);
        end
    endtask

    initial begin
        int c0;
        total   = 0;
        bad     = 0;
        chg_cnt = 0;
        exp_op  = 0;
        rst_n        = 1'b0;
        bus.key_up   = 1'b1;
        bus.key_down = 1'b1;
        bus.dina     = '0;
        bus.dinb     = '0;
        tick(3);
        check_reset_vals("reset");

        // first result two cycles after reset release: ADD overflow
        rst_n = 1'b1;
        apply_one("add_of", 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

        // short glitches are rejected, then a steady press is accepted once
        c0 = chg_cnt;
        repeat (2) begin
            bus.key_up = 1'b0;
            tick(3);
            bus.key_up = 1'b1;
            tick(3);
        end
        check_val("glitch_opcode", 32'(bus.opcode), 0);
        check_val("glitch_chg", 32'(chg_cnt - c0), 0);
        up_press();
        check_val("steady_opcode", 32'(bus.opcode), 1);
        check_val("steady_chg", 32'(chg_cnt - c0), 1);
        apply_one("sub_zero", 8'h05, 8'h05, 8'h00, 1'b1, 1'b0);

        // wrap-around in both directions
        goto_op(0);
        c0 = chg_cnt;
        repeat (9) up_press();
        check_val("wrap9_opcode", 32'(bus.opcode), 0);
        check_val("wrap9_chg", 32'(chg_cnt - c0), 9);
        down_press();
        check_val("down_wrap_opcode", 32'(bus.opcode), 8);

        // shifts with a fixed pattern
        apply_one("sra", 8'h90, 8'h03, 8'hF2, 1'b0, 1'b0);
        down_press();
        check_val("op7", 32'(bus.opcode), 7);
        apply_one("srl", 8'h90, 8'h03, 8'h12, 1'b0, 1'b0);
        down_press();
        check_val("op6", 32'(bus.opcode), 6);
        apply_one("sll", 8'h90, 8'h03, 8'h80, 1'b0, 1'b0);

        // simultaneous up and down presses cancel
        c0 = chg_cnt;
        press_keys(1'b0, 1'b0);
        check_val("both_opcode", 32'(bus.opcode), 6);
        check_val("both_chg", 32'(chg_cnt - c0), 0);

        // every opcode against random operands
        for (int op = 0; op < 9; op++) begin
            goto_op(op);
            run_random(12);
        end

        // reset in the middle of a debounce and an operand stream
        goto_op(3);
        bus.key_up = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.dina = W'($urandom_range(0, 255));
            bus.dinb = W'($urandom_range(0, 255));
            tick(1);
        end
        rst_n      = 1'b0;
        bus.key_up = 1'b1;
        exp_op     = 0;
        for (int i = 0; i < 3; i++) begin
            bus.dina = W'($urandom_range(0, 255));
            tick(1);
        end
        check_reset_vals("mid_reset");
        rst_n = 1'b1;
        c0 = chg_cnt;
        tick(12);
        check_val("post_reset_opcode", 32'(bus.opcode), 0);
        check_val("post_reset_chg", 32'(chg_cnt - c0), 0);

        // key held across reset release: accepted only after a full debounce
        bus.key_up = 1'b0;
        rst_n      = 1'b0;
        tick(3);
        rst_n = 1'b1;
        c0 = chg_cnt;
        tick(3);
        check_val("held_early_opcode", 32'(bus.opcode), 0);
        tick(5);
        check_val("held_late_opcode", 32'(bus.opcode), 1);
        check_val("held_chg", 32'(chg_cnt - c0), 1);
        exp_op = 1;
        bus.key_up = 1'b1;
        tick(DEB + 4);
        run_random(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
